// File: rtl/traf_pkg.sv
// Shared traffic-controller definitions: phase state encodings and the
// one-hot lamp codes for main-street (5-bit) and side-street (3-bit) heads.
// Sibling traffic blocks import this package so the values stay in one place.
package traf_pkg;

   typedef enum logic [3:0] {
      ST_AR0 = 4'd0,
      ST_MG  = 4'd1,
      ST_MY  = 4'd2,
      ST_AR1 = 4'd3,
      ST_SG  = 4'd4,
      ST_SY  = 4'd5,
      ST_AR2 = 4'd6,
      ST_AG  = 4'd7,
      ST_AY  = 4'd8
   } state_e;

   localparam logic [4:0] MS_RED  = 5'b00100;
   localparam logic [4:0] MS_YEL  = 5'b00010;
   localparam logic [4:0] MS_GRN  = 5'b00001;
   localparam logic [4:0] MS_YARW = 5'b01000;
   localparam logic [4:0] MS_GARW = 5'b10000;

   localparam logic [2:0] SS_RED  = 3'b100;
   localparam logic [2:0] SS_YEL  = 3'b010;
   localparam logic [2:0] SS_GRN  = 3'b001;

endpackage

// File: rtl/traf_phase_timer.sv
// Loadable down-counter used to time each phase.
//   CLK, RST_N   : clock, async active-low reset (value returns to RST_VAL)
//   i_load       : load i_load_val this edge (takes priority over counting)
//   i_load_val   : value to load, D-1 of the phase being entered
//   o_value      : current count
//   o_zero       : count is zero (last cycle of the phase)
module traf_phase_timer #(
   parameter int            TW      = 8,
   parameter logic [TW-1:0] RST_VAL = '0
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          i_load,
   input  logic [TW-1:0] i_load_val,
   output logic [TW-1:0] o_value,
   output logic          o_zero
);

   logic [TW-1:0] r_cnt;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)          r_cnt <= RST_VAL;
      else if (i_load)     r_cnt <= i_load_val;
      else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
   end

   assign o_value = r_cnt;
   assign o_zero  = (r_cnt == '0);

endmodule

// File: rtl/traf_phase_scheduler.sv
// Intersection phase scheduler: sequences main / side / turn-arrow phases
// with yellow and all-red clearance, latches walk and turn requests until
// served, and decodes lamp and walk outputs from registered state only.
//   CLK, RST_N                  : clock, async active-low reset
//   turn_ms_sensor              : main-street turn request (level)
//   walk_ms_sensor              : request to cross main street (level)
//   walk_ss_sensor              : request to cross side street (level)
//   ms_1, ms_2                  : main-street heads, one-hot lamp code
//   ss_1, ss_2                  : side-street heads, one-hot lamp code
//   wm, ws                      : walk signals across main / side street
//   phase                       : current state encoding (status/debug)
module traf_phase_scheduler
   import traf_pkg::*;
#(
   parameter int T_MAIN_G  = 40,
   parameter int T_SIDE_G  = 30,
   parameter int T_ARROW_G = 20,
   parameter int T_YEL     = 5,
   parameter int T_RED     = 5,
   parameter int T_WALK    = 10,
   parameter int TW        = 8
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       turn_ms_sensor,
   input  logic       walk_ms_sensor,
   input  logic       walk_ss_sensor,
   output logic [4:0] ms_1,
   output logic [4:0] ms_2,
   output logic [2:0] ss_1,
   output logic [2:0] ss_2,
   output logic       wm,
   output logic       ws,
   output logic [3:0] phase
);

   localparam logic [TW-1:0] L_MAIN  = TW'(T_MAIN_G - 1);
   localparam logic [TW-1:0] L_SIDE  = TW'(T_SIDE_G - 1);
   localparam logic [TW-1:0] L_ARROW = TW'(T_ARROW_G - 1);
   localparam logic [TW-1:0] L_YEL   = TW'(T_YEL - 1);
   localparam logic [TW-1:0] L_RED   = TW'(T_RED - 1);

   state_e        r_state, w_state_nx;
   logic          w_adv;
   logic [TW-1:0] w_load_val, w_timer;
   logic          w_zero;
   logic          r_req_wm, r_req_ws, r_req_turn;
   logic          r_svc_wm, r_svc_ws;

   traf_phase_timer #(.TW(TW), .RST_VAL(L_RED)) u_timer (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .i_load     (w_adv),
      .i_load_val (w_load_val),
      .o_value    (w_timer),
      .o_zero     (w_zero)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) r_state <= ST_AR0;
      else        r_state <= w_state_nx;
   end

   // w_adv marks the edge that enters w_state_nx; the timer reloads then.
   always_comb begin
      w_state_nx = r_state;
      w_adv      = w_zero;
      case (r_state)
         ST_AR0:  if (w_zero) w_state_nx = ST_MG;
         ST_MG:   if (w_zero) w_state_nx = ST_MY;
         ST_MY:   if (w_zero) w_state_nx = ST_AR1;
         ST_AR1:  if (w_zero) w_state_nx = ST_SG;
         ST_SG:   if (w_zero) w_state_nx = ST_SY;
         // Registered req_turn: a request landing on this same edge waits.
         ST_SY:   if (w_zero) w_state_nx = r_req_turn ? ST_AR2 : ST_AR0;
         ST_AR2:  if (w_zero) w_state_nx = ST_AG;
         ST_AG:   if (w_zero) w_state_nx = ST_AY;
         ST_AY:   if (w_zero) w_state_nx = ST_AR0;
         default: begin
            w_state_nx = ST_AR0;
            w_adv      = 1'b1;
         end
      endcase
   end

   always_comb begin
      case (w_state_nx)
         ST_MG:                 w_load_val = L_MAIN;
         ST_SG:                 w_load_val = L_SIDE;
         ST_AG:                 w_load_val = L_ARROW;
         ST_MY, ST_SY, ST_AY:   w_load_val = L_YEL;
         default:               w_load_val = L_RED;
      endcase
   end

   wire w_enter_mg  = w_adv && (w_state_nx == ST_MG);
   wire w_enter_sg  = w_adv && (w_state_nx == ST_SG);
   wire w_enter_ar2 = w_adv && (w_state_nx == ST_AR2);
   wire w_turn_busy = (r_state == ST_AR2) || (r_state == ST_AG) || (r_state == ST_AY);

   // Clearing on entry wins over a sensor seen on the same edge.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_req_wm   <= 1'b0;
         r_req_ws   <= 1'b0;
         r_req_turn <= 1'b0;
         r_svc_wm   <= 1'b0;
         r_svc_ws   <= 1'b0;
      end else begin
         if (w_enter_mg) begin
            r_svc_ws <= r_req_ws;
            r_req_ws <= 1'b0;
         end else if (walk_ss_sensor && r_state != ST_MG) begin
            r_req_ws <= 1'b1;
         end
         if (w_enter_sg) begin
            r_svc_wm <= r_req_wm;
            r_req_wm <= 1'b0;
         end else if (walk_ms_sensor && r_state != ST_SG) begin
            r_req_wm <= 1'b1;
         end
         if (w_enter_ar2)                         r_req_turn <= 1'b0;
         else if (turn_ms_sensor && !w_turn_busy) r_req_turn <= 1'b1;
      end
   end

   // Output decode from registered state, timer and svc flags only.
   always_comb begin
      ms_1 = MS_RED;
      ss_1 = SS_RED;
      case (r_state)
         ST_MG:   ms_1 = MS_GRN;
         ST_MY:   ms_1 = MS_YEL;
         ST_SG:   ss_1 = SS_GRN;
         ST_SY:   ss_1 = SS_YEL;
         ST_AG:   ms_1 = MS_GARW;
         ST_AY:   ms_1 = MS_YARW;
         default: ;
      endcase
   end

   assign ms_2  = ms_1;
   assign ss_2  = ss_1;
   assign phase = r_state;
   // Timer counts D-1 down to 0, so the first T_WALK cycles have timer > D-1-T_WALK.
   assign ws    = (r_state == ST_MG) && r_svc_ws && (int'(w_timer) > T_MAIN_G - 1 - T_WALK);
   assign wm    = (r_state == ST_SG) && r_svc_wm && (int'(w_timer) > T_SIDE_G - 1 - T_WALK);

endmodule
